// File: rtl/kyo_sprite_addr_gen.sv
// Sprite address generator: maps the raster position to a sprite-ROM word
// address and an in-sprite flag, sequences a multi-frame attack animation
// paced by video frames, and mirrors columns when the fighter faces left.
module kyo_sprite_addr_gen #(
  parameter int SPR_W      = 96,
  parameter int SPR_H      = 112,
  parameter int NUM_FRAMES = 6,
  parameter int HOLD_TICKS = 4,
  parameter int ADDR_W     = 17
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              frame_tick,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              facing_left,
  input  logic              trigger,
  output logic [ADDR_W-1:0] rom_address,
  output logic              in_sprite,
  output logic              busy,
  output logic              anim_done,
  output logic [2:0]        frame_idx
);

  localparam int TC_W = $clog2(HOLD_TICKS + 1);
  localparam logic [TC_W-1:0]   LAST_TICK  = TC_W'(HOLD_TICKS - 1);
  localparam logic [2:0]        LAST_FRAME = 3'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0] FRAME_SZ   = ADDR_W'(SPR_W * SPR_H);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state, state_n;
  logic [TC_W-1:0]   tick_cnt, tick_n;
  logic [2:0]        idx_n;
  logic [ADDR_W-1:0] base, base_n;
  logic              done_n;

  logic [9:0]        sx_lat, sy_lat;
  logic              face_lat;

  logic [10:0]       col_p0, row_p0, mcol_p0;
  logic              in_p0;
  logic [ADDR_W-1:0] addr_p0;

  // Position and facing only change at vertical blank so a sprite never tears.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sx_lat   <= '0;
      sy_lat   <= '0;
      face_lat <= 1'b0;
    end else if (frame_tick) begin
      sx_lat   <= sprite_x;
      sy_lat   <= sprite_y;
      face_lat <= facing_left;
    end
  end

  // Animation state register: frame index, hold counter and running frame base.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      frame_idx <= '0;
      base      <= '0;
      anim_done <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      frame_idx <= idx_n;
      base      <= base_n;
      anim_done <= done_n;
    end
  end

  // Next-state logic: the frame base is accumulated rather than multiplied.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    idx_n   = frame_idx;
    base_n  = base;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        idx_n  = '0;
        base_n = '0;
        // A frame_tick coincident with the trigger is deliberately not counted.
        if (trigger) state_n = PLAY;
      end
      PLAY: begin
        // trigger is ignored here: no restart and no queued request.
        if (frame_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_n = '0;
            if (frame_idx < LAST_FRAME) begin
              idx_n  = frame_idx + 3'd1;
              base_n = base + FRAME_SZ;
            end else begin
              idx_n   = '0;
              base_n  = '0;
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == PLAY);

  // Stage p0: hit test, mirroring and address arithmetic on the raw raster position.
  always_comb begin
    col_p0  = {1'b0, draw_x} - {1'b0, sx_lat};
    row_p0  = {1'b0, draw_y} - {1'b0, sy_lat};
    in_p0   = (draw_x >= sx_lat) && (col_p0 < 11'(SPR_W)) &&
              (draw_y >= sy_lat) && (row_p0 < 11'(SPR_H));
    mcol_p0 = face_lat ? (11'(SPR_W - 1) - col_p0) : col_p0;
    addr_p0 = base + ADDR_W'(row_p0) * ADDR_W'(SPR_W) + ADDR_W'(mcol_p0);
  end

  // Stage p0 -> output: register address and flag together, zero outside the box.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      in_sprite   <= 1'b0;
    end else begin
      rom_address <= in_p0 ? addr_p0 : '0;
      in_sprite   <= in_p0;
    end
  end

endmodule

// File: tb/tb_kyo_sprite_addr_gen.sv
// Directed bench for kyo_sprite_addr_gen: raster mapping, mirroring, position
// latching, animation sequencing and asynchronous reset mid-animation.
module tb_kyo_sprite_addr_gen;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  draw_x, draw_y, sprite_x, sprite_y;
  logic        frame_tick, facing_left, trigger;
  logic [16:0] rom_address;
  logic        in_sprite, busy, anim_done;
  logic [2:0]  frame_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  kyo_sprite_addr_gen dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .frame_tick  (frame_tick),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .facing_left (facing_left),
    .trigger     (trigger),
    .rom_address (rom_address),
    .in_sprite   (in_sprite),
    .busy        (busy),
    .anim_done   (anim_done),
    .frame_idx   (frame_idx)
  );

  always #5 vga_clk = ~vga_clk;

  // Count completion pulses, sampled away from the active edge.
  always @(negedge vga_clk) if (anim_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // One frame_tick pulse followed by an idle cycle.
  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; draw_x = '0; draw_y = '0; sprite_x = '0; sprite_y = '0;
    frame_tick = 1'b0; facing_left = 1'b0; trigger = 1'b0;
    step(); step();
    chk("rst_addr", 32'(rom_address), 0);
    chk("rst_in",   32'(in_sprite), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(anim_done), 0);
    chk("rst_idx",  32'(frame_idx), 0);
    reset = 1'b0;

    // Latch sx=100 sy=50 facing right
    sprite_x = 10'd100; sprite_y = 10'd50;
    tick();
    draw_x = 10'd100; draw_y = 10'd50; step();
    chk("tl_in",   32'(in_sprite), 1);
    chk("tl_addr", 32'(rom_address), 0);
    draw_x = 10'd195; draw_y = 10'd161; step();
    chk("br_in",   32'(in_sprite), 1);
    chk("br_addr", 32'(rom_address), 10751);
    draw_x = 10'd196; step();
    chk("right_out_in",   32'(in_sprite), 0);
    chk("right_out_addr", 32'(rom_address), 0);
    draw_x = 10'd99; draw_y = 10'd50; step();
    chk("left_out_in", 32'(in_sprite), 0);
    draw_x = 10'd100; draw_y = 10'd162; step();
    chk("bottom_out_in", 32'(in_sprite), 0);

    // Facing change is not visible until the next frame_tick
    facing_left = 1'b1; draw_x = 10'd100; draw_y = 10'd50; step();
    chk("face_unlatched", 32'(rom_address), 0);
    tick();
    chk("mir_tl", 32'(rom_address), 95);
    draw_x = 10'd195; step();
    chk("mir_tr_in",   32'(in_sprite), 1);
    chk("mir_tr_addr", 32'(rom_address), 0);
    draw_x = 10'd100; draw_y = 10'd51; step();
    chk("mir_row1", 32'(rom_address), 191);

    // Back to facing right, start animation
    facing_left = 1'b0; tick();
    draw_x = 10'd100; draw_y = 10'd50;
    trigger = 1'b1; step(); trigger = 1'b0;
    chk("play_busy", 32'(busy), 1);
    chk("play_idx0", 32'(frame_idx), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("idx_hold", 32'(frame_idx), 0);
    tick();
    chk("idx1",   32'(frame_idx), 1);
    chk("base1",  32'(rom_address), 10752);

    // Mid-frame position change and a trigger during PLAY
    sprite_x = 10'd200; trigger = 1'b1; step(); trigger = 1'b0;
    chk("nolatch_in",   32'(in_sprite), 1);
    chk("nolatch_addr", 32'(rom_address), 10752);
    tick(); // tick 5
    chk("latched_old_out", 32'(in_sprite), 0);
    draw_x = 10'd200; step();
    chk("latched_new_addr", 32'(rom_address), 10752);
    for (int i = 0; i < 15; i++) tick(); // ticks 6..20
    chk("idx5",        32'(frame_idx), 5);
    chk("idx5_busy",   32'(busy), 1);
    chk("idx5_base",   32'(rom_address), 5 * 10752);
    for (int i = 0; i < 3; i++) tick(); // ticks 21..23
    chk("pre_done_cnt", 32'(done_cnt), 0);
    chk("pre_done_busy", 32'(busy), 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("done_pulse", 32'(anim_done), 1);
    chk("done_busy",  32'(busy), 0);
    chk("done_idx",   32'(frame_idx), 0);
    step();
    chk("done_clear", 32'(anim_done), 0);
    chk("done_once",  32'(done_cnt), 1);
    chk("idle_base",  32'(rom_address), 0);

    // Trigger coincident with frame_tick: that tick is not counted
    trigger = 1'b1; frame_tick = 1'b1; step(); trigger = 1'b0; frame_tick = 1'b0;
    chk("coinc_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) tick();
    chk("coinc_idx0", 32'(frame_idx), 0);
    for (int i = 0; i < 9; i++) tick();
    chk("coinc_idx3", 32'(frame_idx), 3);

    // Asynchronous reset mid-animation
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", 32'(busy), 0);
    chk("areset_idx",  32'(frame_idx), 0);
    chk("areset_addr", 32'(rom_address), 0);
    chk("areset_in",   32'(in_sprite), 0);
    chk("areset_done", 32'(anim_done), 0);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_idle", 32'(busy), 0);
    chk("post_rst_done_cnt", 32'(done_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
